// File: rtl/ramio_pkg.sv
// ---------------------------------------------------------------------------
// ramio_pkg
// Shared definitions for the RAMIO arbiter slice: the write-type and
// read-type encodings used on the RAMIO request path, and the arbiter FSM
// state type.
// ---------------------------------------------------------------------------
package ramio_pkg;

    // Write size encoding (write_type[1:0])
    localparam logic [1:0] WRITE_NONE = 2'b00;
    localparam logic [1:0] WRITE_BYTE = 2'b01;
    localparam logic [1:0] WRITE_HALF = 2'b10;
    localparam logic [1:0] WRITE_WORD = 2'b11;

    // Read encoding (read_type[2:0]): bit 2 is the signed flag and
    // [1:0] is the size.
    localparam int         READ_SIGNED_BIT = 2;
    localparam logic [2:0] READ_NONE       = 3'b000;
    localparam logic [2:0] READ_BYTE       = 3'b001;
    localparam logic [2:0] READ_HALF       = 3'b010;
    localparam logic [2:0] READ_WORD       = 3'b011;
    localparam logic [2:0] READ_SIGNED     = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACTIVE
    } arb_state_t;

endpackage

// File: rtl/ramio_arbiter_if.sv
// ---------------------------------------------------------------------------
// ramio_arbiter_if
// One RAMIO-style request/response bundle. The same bundle is used between
// each bus master and the arbiter, and between the arbiter and RAMIO.
//   enable          request, held high for the whole transaction
//   write_type      2-bit write size (see ramio_pkg)
//   read_type       3-bit read size + signed flag (see ramio_pkg)
//   address         32-bit byte address
//   data_in         32-bit write data
//   data_out        32-bit read data
//   data_out_ready  read data valid
//   busy            RAMIO (or arbiter) busy
// Modports:
//   master  drives the request fields, receives the response
//   slave   receives the request fields, drives the response
// ---------------------------------------------------------------------------
interface ramio_arbiter_if;
    import ramio_pkg::*;

    logic        enable;
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        data_out_ready;
    logic        busy;

    modport master (
        output enable, write_type, read_type, address, data_in,
        input  data_out, data_out_ready, busy
    );

    modport slave (
        input  enable, write_type, read_type, address, data_in,
        output data_out, data_out_ready, busy
    );

endinterface

// File: rtl/ramio_rr_pick.sv
// ---------------------------------------------------------------------------
// ramio_rr_pick
// Combinational winner select for two requesters.
//   req[1:0]    request from master 1 / master 0
//   last_grant  master granted most recently
//   grant       index of the winning master (meaningful when valid = 1)
//   valid       at least one master is requesting
// FIXED_PRIORITY = 1 makes master 0 win every tie; 0 gives the tie to the
// master that was not granted last.
// ---------------------------------------------------------------------------
module ramio_rr_pick #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (FIXED_PRIORITY != 0) begin
            grant = ~req[0];
        end else if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/ramio_arbiter.sv
// ---------------------------------------------------------------------------
// ramio_arbiter
// Two-master arbiter for the single RAMIO port. Master 0 is the flash boot
// loader, master 1 is the CPU core. One master owns the RAMIO request path
// per transaction; its request fields are captured into registers at grant
// time and held until it drops enable. Busy and data-ready go back only to
// the owner; the other master is held off with busy.
//   clk, rst_n  clock, asynchronous active-low reset
//   m0, m1      master-side bundles (arbiter is the slave)
//   s           RAMIO-side bundle (arbiter is the master)
// Parameter FIXED_PRIORITY: 0 round-robin, 1 master 0 wins every tie.
// ---------------------------------------------------------------------------
module ramio_arbiter
    import ramio_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    ramio_arbiter_if.slave  m0,
    ramio_arbiter_if.slave  m1,
    ramio_arbiter_if.master s
);

    arb_state_t  state;
    arb_state_t  next_state;

    logic        owner;
    logic        last_grant;
    logic        pick_grant;
    logic        pick_valid;
    logic        grant_now;
    logic        release_now;
    logic        owner_enable;

    logic        s_enable_q;
    logic [1:0]  s_write_type_q;
    logic [2:0]  s_read_type_q;
    logic [31:0] s_address_q;
    logic [31:0] s_data_in_q;

    ramio_rr_pick #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .req        ({m1.enable, m0.enable}),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ISSUE forces busy on both masters for one cycle because RAMIO has not
    // yet had a chance to raise its own busy; without it the owner could see
    // busy=0 and take the transaction as already finished.
    always_comb begin
        next_state        = state;
        grant_now         = 1'b0;
        release_now       = 1'b0;
        owner_enable      = owner ? m1.enable : m0.enable;
        m0.busy           = 1'b1;
        m1.busy           = 1'b1;
        m0.data_out_ready = 1'b0;
        m1.data_out_ready = 1'b0;

        case (state)
            IDLE: begin
                m0.busy = s.busy;
                m1.busy = s.busy;
                if (!s.busy && pick_valid) begin
                    grant_now  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = ACTIVE;
            end
            ACTIVE: begin
                if (owner) begin
                    m1.busy           = s.busy;
                    m1.data_out_ready = s.data_out_ready;
                end else begin
                    m0.busy           = s.busy;
                    m0.data_out_ready = s.data_out_ready;
                end
                if (!owner_enable) begin
                    release_now = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request fields are captured only at grant, so later changes on the
    // owner's inputs have no effect until the next transaction. Address and
    // data are left as-is on release; only enable and the type fields clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            s_enable_q     <= 1'b0;
            s_write_type_q <= WRITE_NONE;
            s_read_type_q  <= READ_NONE;
            s_address_q    <= '0;
            s_data_in_q    <= '0;
        end else if (grant_now) begin
            owner          <= pick_grant;
            last_grant     <= pick_grant;
            s_enable_q     <= 1'b1;
            s_write_type_q <= pick_grant ? m1.write_type : m0.write_type;
            s_read_type_q  <= pick_grant ? m1.read_type  : m0.read_type;
            s_address_q    <= pick_grant ? m1.address    : m0.address;
            s_data_in_q    <= pick_grant ? m1.data_in    : m0.data_in;
        end else if (release_now) begin
            s_enable_q     <= 1'b0;
            s_write_type_q <= WRITE_NONE;
            s_read_type_q  <= READ_NONE;
        end
    end

    assign s.enable     = s_enable_q;
    assign s.write_type = s_write_type_q;
    assign s.read_type  = s_read_type_q;
    assign s.address    = s_address_q;
    assign s.data_in    = s_data_in_q;

    assign m0.data_out  = s.data_out;
    assign m1.data_out  = s.data_out;

endmodule

// File: tb/tb_ramio_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ramio_arbiter
// Drives a round-robin and a fixed-priority arbiter with identical master
// and RAMIO inputs. A directed cycle table, hand-written grant sequences and
// a randomized run compare both instances against expected values; the
// randomized run uses a transaction-level model kept in this bench.
// ---------------------------------------------------------------------------
module tb_ramio_arbiter;
    import ramio_pkg::*;

    localparam logic [31:0] ADDR0   = 32'h0000_0010;
    localparam logic [31:0] DATA0   = 32'hDEAD_BEEF;
    localparam logic [31:0] ADDR1   = 32'h0000_0004;
    localparam logic [31:0] DATA1   = 32'h0000_0000;
    localparam logic [31:0] RD_DATA = 32'h0000_5537;

    logic        clk;
    logic        rst_n;
    logic        e0, e1;
    logic [1:0]  wt0, wt1;
    logic [2:0]  rt0, rt1;
    logic [31:0] a0, a1, d0, d1;
    logic        sb, sr;
    logic [31:0] s_dout;

    int errors = 0;
    int checks = 0;

    ramio_arbiter_if rr_m0 ();
    ramio_arbiter_if rr_m1 ();
    ramio_arbiter_if rr_s ();
    ramio_arbiter_if fp_m0 ();
    ramio_arbiter_if fp_m1 ();
    ramio_arbiter_if fp_s ();

    assign rr_m0.enable = e0;  assign rr_m0.write_type = wt0; assign rr_m0.read_type = rt0;
    assign rr_m0.address = a0; assign rr_m0.data_in = d0;
    assign rr_m1.enable = e1;  assign rr_m1.write_type = wt1; assign rr_m1.read_type = rt1;
    assign rr_m1.address = a1; assign rr_m1.data_in = d1;
    assign rr_s.busy = sb;     assign rr_s.data_out_ready = sr; assign rr_s.data_out = s_dout;

    assign fp_m0.enable = e0;  assign fp_m0.write_type = wt0; assign fp_m0.read_type = rt0;
    assign fp_m0.address = a0; assign fp_m0.data_in = d0;
    assign fp_m1.enable = e1;  assign fp_m1.write_type = wt1; assign fp_m1.read_type = rt1;
    assign fp_m1.address = a1; assign fp_m1.data_in = d1;
    assign fp_s.busy = sb;     assign fp_s.data_out_ready = sr; assign fp_s.data_out = s_dout;

    ramio_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (rr_m0.slave),
        .m1    (rr_m1.slave),
        .s     (rr_s.master)
    );

    ramio_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (fp_m0.slave),
        .m1    (fp_m1.slave),
        .s     (fp_s.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        s_en;
        logic [1:0]  s_wt;
        logic [2:0]  s_rt;
        logic [31:0] s_addr;
        logic [31:0] s_din;
        logic        busy0, busy1, rdy0, rdy1;
        logic [31:0] dout0, dout1;
    } obs_t;

    typedef struct {
        logic        e0, e1, sb, sr;
        logic        s_en;
        logic [1:0]  wt;
        logic [2:0]  rt;
        logic [31:0] addr, din;
        logic        b0, b1, r0, r1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int ie0, input int ie1, input int isb, input int isr,
                                input int en, input int wt, input int rt,
                                input logic [31:0] addr, input logic [31:0] din,
                                input int b0, input int b1, input int r0, input int r1);
        vec_t v;
        v.e0 = 1'(ie0); v.e1 = 1'(ie1); v.sb = 1'(isb); v.sr = 1'(isr);
        v.s_en = 1'(en); v.wt = 2'(wt); v.rt = 3'(rt); v.addr = addr; v.din = din;
        v.b0 = 1'(b0); v.b1 = 1'(b1); v.r0 = 1'(r0); v.r1 = 1'(r1);
        return v;
    endfunction

    function automatic obs_t sample(input int fp);
        obs_t o;
        if (fp != 0) begin
            o.s_en = fp_s.enable;  o.s_wt = fp_s.write_type; o.s_rt = fp_s.read_type;
            o.s_addr = fp_s.address; o.s_din = fp_s.data_in;
            o.busy0 = fp_m0.busy;  o.busy1 = fp_m1.busy;
            o.rdy0 = fp_m0.data_out_ready; o.rdy1 = fp_m1.data_out_ready;
            o.dout0 = fp_m0.data_out; o.dout1 = fp_m1.data_out;
        end else begin
            o.s_en = rr_s.enable;  o.s_wt = rr_s.write_type; o.s_rt = rr_s.read_type;
            o.s_addr = rr_s.address; o.s_din = rr_s.data_in;
            o.busy0 = rr_m0.busy;  o.busy1 = rr_m1.busy;
            o.rdy0 = rr_m0.data_out_ready; o.rdy1 = rr_m1.data_out_ready;
            o.dout0 = rr_m0.data_out; o.dout1 = rr_m1.data_out;
        end
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int fp, input obs_t exp);
        obs_t act;
        act = sample(fp);
        checkOutput($sformatf("%s.dut%0d.s_enable", tag, fp), 32'(act.s_en), 32'(exp.s_en));
        checkOutput($sformatf("%s.dut%0d.s_write_type", tag, fp), 32'(act.s_wt), 32'(exp.s_wt));
        checkOutput($sformatf("%s.dut%0d.s_read_type", tag, fp), 32'(act.s_rt), 32'(exp.s_rt));
        checkOutput($sformatf("%s.dut%0d.s_address", tag, fp), act.s_addr, exp.s_addr);
        checkOutput($sformatf("%s.dut%0d.s_data_in", tag, fp), act.s_din, exp.s_din);
        checkOutput($sformatf("%s.dut%0d.m0_busy", tag, fp), 32'(act.busy0), 32'(exp.busy0));
        checkOutput($sformatf("%s.dut%0d.m1_busy", tag, fp), 32'(act.busy1), 32'(exp.busy1));
        checkOutput($sformatf("%s.dut%0d.m0_ready", tag, fp), 32'(act.rdy0), 32'(exp.rdy0));
        checkOutput($sformatf("%s.dut%0d.m1_ready", tag, fp), 32'(act.rdy1), 32'(exp.rdy1));
        checkOutput($sformatf("%s.dut%0d.m0_data_out", tag, fp), act.dout0, exp.dout0);
        checkOutput($sformatf("%s.dut%0d.m1_data_out", tag, fp), act.dout1, exp.dout1);
    endtask

    task automatic applyStimulus(input logic ie0, input logic ie1, input logic isb, input logic isr);
        e0 = ie0; e1 = ie1; sb = isb; sr = isr;
    endtask

    task automatic setFixedFields();
        wt0 = WRITE_WORD; rt0 = READ_NONE; a0 = ADDR0; d0 = DATA0;
        wt1 = WRITE_NONE; rt1 = READ_HALF; a1 = ADDR1; d1 = DATA1;
        s_dout = RD_DATA;
    endtask

    function automatic obs_t resetObs();
        obs_t o;
        o.s_en = 1'b0; o.s_wt = '0; o.s_rt = '0; o.s_addr = '0; o.s_din = '0;
        o.busy0 = sb; o.busy1 = sb; o.rdy0 = 1'b0; o.rdy1 = 1'b0;
        o.dout0 = s_dout; o.dout1 = s_dout;
        return o;
    endfunction

    // Reset with busy/ready both high and then both low: busy must follow
    // RAMIO busy and ready must stay low while in reset.
    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        for (int k = 0; k < 2; k++) checkAll("reset_busy_hi", k, resetObs());
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        for (int k = 0; k < 2; k++) checkAll("reset_busy_lo", k, resetObs());
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Grant already decided at the previous edge; walks ISSUE, ACTIVE
    // (owner releases) and IDLE, where the next round's requests are set.
    task automatic runGrant(input int fp, input int exp_w, input logic nxt0, input logic nxt1,
                            input string tag);
        obs_t o;
        @(negedge clk);
        #1 o = sample(fp);
        checkOutput($sformatf("%s.issue_en", tag), 32'(o.s_en), 32'd1);
        checkOutput($sformatf("%s.winner_addr", tag), o.s_addr, (exp_w != 0) ? ADDR1 : ADDR0);
        checkOutput($sformatf("%s.issue_wait_busy", tag), 32'((exp_w != 0) ? o.busy0 : o.busy1), 32'd1);
        @(negedge clk);
        if (exp_w == 0) e0 = 1'b0; else e1 = 1'b0;
        #1 o = sample(fp);
        checkOutput($sformatf("%s.active_en", tag), 32'(o.s_en), 32'd1);
        checkOutput($sformatf("%s.active_wait_busy", tag), 32'((exp_w != 0) ? o.busy0 : o.busy1), 32'd1);
        checkOutput($sformatf("%s.active_owner_busy", tag), 32'((exp_w != 0) ? o.busy1 : o.busy0), 32'd0);
        @(negedge clk);
        e0 = nxt0; e1 = nxt1;
        #1 o = sample(fp);
        checkOutput($sformatf("%s.idle_en", tag), 32'(o.s_en), 32'd0);
    endtask

    // Transaction-level reference: one entry per instance (0 round-robin,
    // 1 fixed priority). age counts cycles since the grant.
    bit          md_txn[2];
    int          md_age[2];
    int          md_owner[2];
    int          md_last[2];
    logic        md_en[2];
    logic [1:0]  md_wt[2];
    logic [2:0]  md_rt[2];
    logic [31:0] md_addr[2];
    logic [31:0] md_din[2];

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            md_txn[k] = 1'b0; md_age[k] = 0; md_owner[k] = 0; md_last[k] = 1;
            md_en[k] = 1'b0; md_wt[k] = '0; md_rt[k] = '0; md_addr[k] = '0; md_din[k] = '0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            int w;
            if (!md_txn[k]) begin
                if (!sb && (e0 || e1)) begin
                    if (e0 && e1) w = (k == 1) ? 0 : 1 - md_last[k];
                    else          w = e1 ? 1 : 0;
                    md_en[k]   = 1'b1;
                    md_wt[k]   = (w == 1) ? wt1 : wt0;
                    md_rt[k]   = (w == 1) ? rt1 : rt0;
                    md_addr[k] = (w == 1) ? a1 : a0;
                    md_din[k]  = (w == 1) ? d1 : d0;
                    md_owner[k] = w; md_last[k] = w;
                    md_txn[k] = 1'b1; md_age[k] = 0;
                end
            end else if (md_age[k] == 0) begin
                md_age[k] = 1;
            end else if (!((md_owner[k] == 1) ? e1 : e0)) begin
                md_en[k] = 1'b0; md_wt[k] = '0; md_rt[k] = '0;
                md_txn[k] = 1'b0;
            end
        end
    endtask

    function automatic obs_t modelExpect(input int k);
        obs_t o;
        o.s_en = md_en[k]; o.s_wt = md_wt[k]; o.s_rt = md_rt[k];
        o.s_addr = md_addr[k]; o.s_din = md_din[k];
        o.dout0 = s_dout; o.dout1 = s_dout;
        o.rdy0 = 1'b0; o.rdy1 = 1'b0;
        if (!md_txn[k]) begin
            o.busy0 = sb; o.busy1 = sb;
        end else if (md_age[k] == 0) begin
            o.busy0 = 1'b1; o.busy1 = 1'b1;
        end else begin
            o.busy0 = (md_owner[k] == 0) ? sb : 1'b1;
            o.busy1 = (md_owner[k] == 1) ? sb : 1'b1;
            o.rdy0  = (md_owner[k] == 0) ? sr : 1'b0;
            o.rdy1  = (md_owner[k] == 1) ? sr : 1'b0;
        end
        return o;
    endfunction

    initial begin
        obs_t exp;
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        setFixedFields();

        // Directed cycle table: word write by m0, half read by m1 with data
        // return, busy gating in IDLE, owner dropping enable during ISSUE.
        vecs.push_back(mk(0,0,0,0, 0,0,0,'0,'0,       0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,'0,'0,       0,0,0,0));
        vecs.push_back(mk(1,0,0,0, 1,3,0,ADDR0,DATA0, 1,1,0,0));
        vecs.push_back(mk(1,0,1,0, 1,3,0,ADDR0,DATA0, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0, 1,3,0,ADDR0,DATA0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,3,0,ADDR0,DATA0, 0,1,0,0));
        vecs.push_back(mk(0,1,0,0, 0,0,0,ADDR0,DATA0, 0,0,0,0));
        vecs.push_back(mk(0,1,0,1, 1,0,2,ADDR1,DATA1, 1,1,0,0));
        vecs.push_back(mk(0,1,1,0, 1,0,2,ADDR1,DATA1, 1,1,0,0));
        vecs.push_back(mk(0,1,0,1, 1,0,2,ADDR1,DATA1, 1,0,0,1));
        vecs.push_back(mk(0,0,0,0, 1,0,2,ADDR1,DATA1, 1,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,0,0,ADDR1,DATA1, 1,1,0,0));
        vecs.push_back(mk(1,0,1,0, 0,0,0,ADDR1,DATA1, 1,1,0,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,ADDR1,DATA1, 0,0,0,0));
        vecs.push_back(mk(0,0,0,0, 1,3,0,ADDR0,DATA0, 1,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,3,0,ADDR0,DATA0, 0,1,0,0));
        vecs.push_back(mk(0,0,0,0, 0,0,0,ADDR0,DATA0, 0,0,0,0));

        applyReset();
        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].e0, vecs[i].e1, vecs[i].sb, vecs[i].sr);
            #1;
            exp.s_en = vecs[i].s_en; exp.s_wt = vecs[i].wt; exp.s_rt = vecs[i].rt;
            exp.s_addr = vecs[i].addr; exp.s_din = vecs[i].din;
            exp.busy0 = vecs[i].b0; exp.busy1 = vecs[i].b1;
            exp.rdy0 = vecs[i].r0; exp.rdy1 = vecs[i].r1;
            exp.dout0 = RD_DATA; exp.dout1 = RD_DATA;
            for (int k = 0; k < 2; k++) checkAll($sformatf("vec%0d", i), k, exp);
        end

        // Round-robin tie from reset: grant order 0, 1, 0, 1.
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        runGrant(0, 0, 1'b1, 1'b1, "rr0");
        runGrant(0, 1, 1'b1, 1'b1, "rr1");
        runGrant(0, 0, 1'b1, 1'b1, "rr2");
        runGrant(0, 1, 1'b0, 1'b0, "rr3");

        // Fixed priority: master 0 keeps winning until it stops requesting.
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        runGrant(1, 0, 1'b1, 1'b1, "fp0");
        runGrant(1, 0, 1'b1, 1'b1, "fp1");
        runGrant(1, 0, 1'b0, 1'b1, "fp2");
        runGrant(1, 1, 1'b0, 1'b0, "fp3");

        // Reset during ACTIVE, then a tie right after release goes to m0.
        applyReset();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("midrst.pre.dut%0d.s_enable", k), 32'(sample(k).s_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) checkAll("midrst.async", k, resetObs());
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        exp.s_en = 1'b1; exp.s_wt = WRITE_WORD; exp.s_rt = READ_NONE;
        exp.s_addr = ADDR0; exp.s_din = DATA0;
        exp.busy0 = 1'b1; exp.busy1 = 1'b1; exp.rdy0 = 1'b0; exp.rdy1 = 1'b0;
        exp.dout0 = RD_DATA; exp.dout1 = RD_DATA;
        for (int k = 0; k < 2; k++) checkAll("midrst.first_tie", k, exp);

        // Randomized traffic against the reference model.
        applyReset();
        modelReset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) e0 = ~e0;
            if ($urandom_range(0, 3) == 0) e1 = ~e1;
            wt0 = 2'($urandom); rt0 = 3'($urandom); a0 = $urandom; d0 = $urandom;
            wt1 = 2'($urandom); rt1 = 3'($urandom); a1 = $urandom; d1 = $urandom;
            sb = ($urandom_range(0, 2) == 0);
            sr = 1'($urandom);
            s_dout = $urandom;
            #1;
            for (int k = 0; k < 2; k++) checkAll($sformatf("rand%0d", c), k, modelExpect(k));
            @(posedge clk);
            modelStep();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ramio_arbiter.md
# ramio_arbiter

Two-master arbiter for the single RAMIO port. Master 0 is the flash boot loader; master 1 is the CPU core. The block grants the RAMIO request path to one master per transaction and forwards the selected master's request fields as registered outputs. It routes busy and data-ready status back only to the owner and holds the other master off with busy until the transaction completes.

## Interface
Parameters:
- FIXED_PRIORITY, default 0: 0 selects round-robin; 1 means master 0 always wins a tie.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_enable, m1_enable  in  1  transaction request, held high until the master is done
- m0_write_type, m1_write_type  in  2  00 none, 01 byte, 10 half, 11 word
- m0_read_type, m1_read_type  in  3  000 none; bit2 is the signed flag; [1:0] is the size
- m0_address, m1_address  in  32  byte address
- m0_data_in, m1_data_in  in  32  write data
- m0_data_out, m1_data_out  out  32  both driven as a copy of s_data_out
- m0_data_out_ready, m1_data_out_ready  out  1  s_data_out_ready gated to the owner
- m0_busy, m1_busy  out  1  per-master busy
- s_enable  out  1  to RAMIO
- s_write_type  out  2  to RAMIO
- s_read_type  out  3  to RAMIO
- s_address  out  32  to RAMIO
- s_data_in  out  32  to RAMIO
- s_data_out  in  32  from RAMIO
- s_data_out_ready  in  1  from RAMIO
- s_busy  in  1  from RAMIO

## Operation
- States: IDLE, ISSUE, ACTIVE.
- IDLE
  - m_busy[i] equals s_busy for both masters.
  - If s_busy is 0 and any m_enable is high, pick a winner:
    - FIXED_PRIORITY=1: master 0 wins.
    - FIXED_PRIORITY=0: a single requester wins; on a tie, the master not granted last (last_grant pointer) wins.
  - On a grant, capture the winner's write_type, read_type, address and data_in into the s_* registers, set s_enable to 1, record owner and last_grant, and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - Both m_busy are 1, so the owner cannot mistake pre-response RAMIO idleness for completion.
  - Next state is always ACTIVE.
- ACTIVE
  - Owner: m_busy = s_busy and m_data_out_ready = s_data_out_ready.
  - Non-owner: m_busy = 1 and m_data_out_ready = 0.
  - When the owner's m_enable is 0: s_enable <= 0, clear the s_* type fields to 0, go to IDLE.
- Captured request fields stay constant for the whole grant. Owner changes to its inputs while enable is high are ignored.
- data_out_ready outside ACTIVE is 0 for both masters.

## Timing
- Reset values:
  - s_enable, s_write_type, s_read_type, s_address, s_data_in are 0.
  - State is IDLE; owner is 0; last_grant is 1, so master 0 wins the first round-robin tie.
  - m_busy follows s_busy, as in IDLE; data_out_ready outputs are 0.
- Grant latency:
  - m_enable high in cycle t with s_busy=0 gives s_enable high in t+1 (ISSUE).
  - m_busy tracks s_busy from t+2 (ACTIVE).
- Release:
  - Owner enable low in cycle u gives s_enable low in u+1 (IDLE).
  - The earliest next grant is decided in u+1, so the next s_enable is high in u+2. There is at least one idle cycle between transactions.
- RAMIO contract: s_busy or s_data_out_ready must respond within 1 cycle of s_enable.
- Simultaneous events:
  - Owner release plus a pending request from the other master: release completes first, then the waiting master is granted (u+1 decision).
  - Both masters request in IDLE with FIXED_PRIORITY=0: the pointer decides; the loser sees busy=1 from the next cycle.
- Boundary cases:
  - Owner drops enable during ISSUE: ISSUE still proceeds to ACTIVE, which releases in the next cycle.
  - s_busy high in IDLE: no grant is made, and both masters see busy.
- Reset mid-transaction: asynchronous return to reset values, and the in-flight RAMIO request is dropped. RAMIO is reset by the same rst_n.

## Structure
- Shared package ramio_pkg:
  - write-type constants (NONE/BYTE/HALF/WORD)
  - read-type constants, including the signed flag bit
  - the arbiter state enum
- Sub-module ramio_rr_pick: combinational winner select from {req[1:0], last_grant, FIXED_PRIORITY} producing grant index and valid.

## Test plan
- Single write:
  - Stimulus: master 0 requests word write 0xDEADBEEF to address 0x10.
  - Required: s_enable high one cycle later with matching fields; m0_busy follows s_busy from the second cycle; s_enable drops the cycle after m0_enable drops.
- Read forwarding:
  - Stimulus: master 1 issues a half-word unsigned read (read_type 010) of address 0x4; RAMIO returns 0x00005537.
  - Required: m1_data_out_ready pulses with data 0x00005537; m0_data_out_ready stays 0.
- Round-robin tie (FIXED_PRIORITY=0):
  - Stimulus: both masters request in the same cycle from reset, then re-request continuously.
  - Required: grant order is 0, 1, 0, 1; the waiting master's busy is 1 throughout.
- Fixed priority (FIXED_PRIORITY=1):
  - Stimulus: both masters request continuously.
  - Required: master 0 is always granted and master 1 waits until master 0 stops.
- Busy gating:
  - Stimulus: hold s_busy=1 in IDLE with a pending request.
  - Required: no s_enable until s_busy falls; the grant follows in the next cycle.
- Reset mid-transaction:
  - Stimulus: assert rst_n low during ACTIVE.
  - Required: all s_* outputs are 0 immediately; after release the first tie goes to master 0.
